frame_serializer: RTL and testbench



---
 rtl/frame_serializer.sv | 157 +++++++++++++++
 tb/tb_frame_serializer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_serializer.sv
// -----------------------------------------------------------------------------
// frame_serializer
//
// Purpose:
//   Takes a DATA_W-bit payload over a valid/ready handshake and wraps it as
//   {1'b1, data, 1'b1}. The framed word is held on a parallel output. It is
//   also shifted out one bit per clock on a single registered serial line.
//   Optionally, a fixed number of idle cycles follows each frame. A wrapping
//   counter records how many frames have been fully sent.
//
// Parameters:
//   DATA_W     payload width; the frame width is DATA_W+2
//   MSB_FIRST  1 = send frame bit FRAME_W-1 first, 0 = send bit 0 first
//   IDLE_LEVEL level driven on ser_o whenever no frame bit is being sent
//   GAP        idle cycles forced after every frame (0..15)
//   CNT_W      width of the completed-frame counter
//
// Ports:
//   clk        sole clock; all state changes on the rising edge
//   rst        synchronous, active-high reset
//   in_data    payload word
//   in_valid   payload present
//   in_ready   block accepts in_data this cycle (depends on state/k only)
//   frame_o    last accepted framed word, held until the next accept
//   ser_o      registered serial bit stream
//   busy       high while shifting or sitting in the post-frame gap
//   last_o     high in the cycle ser_o carries the final frame bit
//   frame_cnt  completed frames, modulo 2^CNT_W
// -----------------------------------------------------------------------------
module frame_serializer #(
    parameter int DATA_W     = 3,
    parameter int MSB_FIRST  = 1,
    parameter int IDLE_LEVEL = 0,
    parameter int GAP        = 0,
    parameter int CNT_W      = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [DATA_W+1:0]   frame_o,
    output logic                ser_o,
    output logic                busy,
    output logic                last_o,
    output logic [CNT_W-1:0]    frame_cnt
);

    localparam int FRAME_W = DATA_W + 2;
    localparam int K_W     = $clog2(FRAME_W);

    localparam logic [K_W-1:0] K_LAST   = K_W'(FRAME_W - 1);
    localparam logic           IDLE_BIT = (IDLE_LEVEL != 0);
    localparam logic           BACK2BACK = (GAP == 0);
    localparam logic [3:0]     GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [1:0]         state;
    logic [K_W-1:0]     k;
    logic [3:0]         gap_cnt;
    logic [FRAME_W-1:0] shreg;
    logic [FRAME_W-1:0] framed;
    logic               k_last;
    logic               frame_done;
    logic               accept;

    // Handshake and status decode.
    // In a zero-gap build, the final shift cycle also accepts a new word.
    // That lets the next frame follow without an idle bit.
    always_comb begin
        framed     = {1'b1, in_data, 1'b1};
        k_last     = (k == K_LAST);
        frame_done = (state == S_SHIFT) && k_last;
        in_ready   = (state == S_IDLE) || (frame_done && BACK2BACK);
        accept     = in_valid && in_ready;
        busy       = (state == S_SHIFT) || (state == S_GAP);
        last_o     = frame_done;
    end

    // Main sequencer.
    // shreg holds the bits still to be sent. They are pre-aligned so the next
    // bit always sits at the same end of the register. The first bit goes
    // straight into ser_o on the accept edge, which gives one cycle of latency.
    // frame_cnt counts on the edge that ends the last bit. It counts whether
    // or not a back-to-back accept happens on that same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            k         <= '0;
            gap_cnt   <= '0;
            shreg     <= '0;
            frame_o   <= '0;
            ser_o     <= IDLE_BIT;
            frame_cnt <= '0;
        end else begin
            if (frame_done) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end

            if (accept) begin
                state   <= S_SHIFT;
                k       <= '0;
                gap_cnt <= '0;
                frame_o <= framed;
                if (MSB_FIRST != 0) begin
                    ser_o <= framed[FRAME_W-1];
                    shreg <= framed << 1;
                end else begin
                    ser_o <= framed[0];
                    shreg <= framed >> 1;
                end
            end else begin
                case (state)
                    S_SHIFT: begin
                        if (k_last) begin
                            ser_o   <= IDLE_BIT;
                            gap_cnt <= '0;
                            if (GAP > 0) begin
                                state <= S_GAP;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else begin
                            k <= k + K_W'(1);
                            if (MSB_FIRST != 0) begin
                                ser_o <= shreg[FRAME_W-1];
                                shreg <= shreg << 1;
                            end else begin
                                ser_o <= shreg[0];
                                shreg <= shreg >> 1;
                            end
                        end
                    end
                    S_GAP: begin
                        ser_o <= IDLE_BIT;
                        if (gap_cnt == GAP_LAST) begin
                            state <= S_IDLE;
                        end else begin
                            gap_cnt <= gap_cnt + 4'd1;
                        end
                    end
                    S_IDLE: begin
                        ser_o <= IDLE_BIT;
                    end
                    default: begin
                        state <= S_IDLE;
                        ser_o <= IDLE_BIT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frame_serializer.sv
// -----------------------------------------------------------------------------
// tb_frame_serializer
//
// Purpose:
//   Self-checking bench for frame_serializer. Four instances cover four builds:
//     0: defaults (MSB first, no gap)
//     1: LSB first
//     2: GAP=2
//     3: CNT_W=2 with GAP=1
//   Stimulus queues the hand-computed serial pattern, framed word and counter
//   value for each frame. An independent monitor tracks each instance's
//   expected cycle role (shift, gap or idle) and compares against the queue.
// -----------------------------------------------------------------------------
module tb_frame_serializer;

    typedef struct packed {
        logic [4:0] ser;
        logic [4:0] frame;
        logic [3:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_v   [4];
    logic       valid_v [4];
    logic [2:0] data_v  [4];
    logic       rdy_v   [4];
    logic       ser_v   [4];
    logic       busy_v  [4];
    logic       last_v  [4];
    logic [4:0] fo_v    [4];
    logic [3:0] cnt_v   [4];
    logic [3:0] cnt0, cnt1, cnt2;
    logic [1:0] cnt3;

    int gap_of [4] = '{0, 0, 2, 1};

    exp_t       exp_q [4][$];
    int         bits_left [4];
    int         gap_left  [4];
    logic [4:0] coll      [4];
    logic       pend      [4];
    logic [3:0] pend_cnt  [4];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    frame_serializer u0 (
        .clk(clk), .rst(rst_v[0]), .in_data(data_v[0]), .in_valid(valid_v[0]),
        .in_ready(rdy_v[0]), .frame_o(fo_v[0]), .ser_o(ser_v[0]), .busy(busy_v[0]),
        .last_o(last_v[0]), .frame_cnt(cnt0));

    frame_serializer #(.MSB_FIRST(0)) u1 (
        .clk(clk), .rst(rst_v[1]), .in_data(data_v[1]), .in_valid(valid_v[1]),
        .in_ready(rdy_v[1]), .frame_o(fo_v[1]), .ser_o(ser_v[1]), .busy(busy_v[1]),
        .last_o(last_v[1]), .frame_cnt(cnt1));

    frame_serializer #(.GAP(2)) u2 (
        .clk(clk), .rst(rst_v[2]), .in_data(data_v[2]), .in_valid(valid_v[2]),
        .in_ready(rdy_v[2]), .frame_o(fo_v[2]), .ser_o(ser_v[2]), .busy(busy_v[2]),
        .last_o(last_v[2]), .frame_cnt(cnt2));

    frame_serializer #(.CNT_W(2), .GAP(1)) u3 (
        .clk(clk), .rst(rst_v[3]), .in_data(data_v[3]), .in_valid(valid_v[3]),
        .in_ready(rdy_v[3]), .frame_o(fo_v[3]), .ser_o(ser_v[3]), .busy(busy_v[3]),
        .last_o(last_v[3]), .frame_cnt(cnt3));

    always_comb begin
        cnt_v[0] = cnt0;
        cnt_v[1] = cnt1;
        cnt_v[2] = cnt2;
        cnt_v[3] = {2'b00, cnt3};
    end

    task automatic checkOutput(input string name, input int inst,
                               input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL inst%0d %s: got %0h expected %0h", inst, name, act, req);
        end
    endtask

    // Monitor: on every falling edge, decide what each instance should be
    // doing (sending bit n, sitting in the gap, or idle) and compare.
    // A completed frame pops the scoreboard entry. The frame_cnt check waits
    // one cycle because the counter updates on the edge that ends the frame.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            if (rst_v[i]) begin
                bits_left[i] = 0;
                gap_left[i]  = 0;
                pend[i]      = 1'b0;
                coll[i]      = '0;
            end else begin
                if (pend[i]) begin
                    checkOutput("frame_cnt", i, 32'(cnt_v[i]), 32'(pend_cnt[i]));
                    pend[i] = 1'b0;
                end
                if (bits_left[i] > 0) begin
                    checkOutput("busy_shift", i, 32'(busy_v[i]), 32'd1);
                    checkOutput("last_o", i, 32'(last_v[i]), 32'(bits_left[i] == 1));
                    checkOutput("ready_shift", i, 32'(rdy_v[i]),
                                32'((bits_left[i] == 1) && (gap_of[i] == 0)));
                    coll[i] = {coll[i][3:0], ser_v[i]};
                    bits_left[i]--;
                    if (bits_left[i] == 0) begin
                        if (exp_q[i].size() == 0) begin
                            checkOutput("unexpected_frame", i, 32'd1, 32'd0);
                        end else begin
                            e = exp_q[i].pop_front();
                            checkOutput("ser_stream", i, 32'(coll[i]), 32'(e.ser));
                            checkOutput("frame_o", i, 32'(fo_v[i]), 32'(e.frame));
                            pend[i]     = 1'b1;
                            pend_cnt[i] = e.cnt;
                        end
                        gap_left[i] = gap_of[i];
                    end
                end else if (gap_left[i] > 0) begin
                    checkOutput("ser_gap", i, 32'(ser_v[i]), 32'd0);
                    checkOutput("busy_gap", i, 32'(busy_v[i]), 32'd1);
                    checkOutput("ready_gap", i, 32'(rdy_v[i]), 32'd0);
                    gap_left[i]--;
                end else begin
                    checkOutput("ser_idle", i, 32'(ser_v[i]), 32'd0);
                    checkOutput("busy_idle", i, 32'(busy_v[i]), 32'd0);
                    checkOutput("ready_idle", i, 32'(rdy_v[i]), 32'd1);
                    checkOutput("last_idle", i, 32'(last_v[i]), 32'd0);
                end
                if (valid_v[i] && rdy_v[i]) begin
                    checkOutput("accept_allowed", i,
                                32'((bits_left[i] == 0) && (gap_left[i] == 0)), 32'd1);
                    bits_left[i] = 5;
                    gap_left[i]  = 0;
                    coll[i]      = '0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the expected result, then hold valid until the word is taken.
    task automatic applyStimulus(input int i, input logic [2:0] d, input logic [4:0] eser,
                                 input logic [4:0] efr, input logic [3:0] ecnt);
        exp_t e;
        logic taken;
        e.ser   = eser;
        e.frame = efr;
        e.cnt   = ecnt;
        exp_q[i].push_back(e);
        data_v[i]  = d;
        valid_v[i] = 1'b1;
        taken      = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (rdy_v[i]) begin
                taken = 1'b1;
                break;
            end
        end
        if (!taken) checkOutput("accept_timeout", i, 32'd0, 32'd1);
        tick();
        valid_v[i] = 1'b0;
    endtask

    task automatic waitDone(input int i);
        logic done;
        done = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (exp_q[i].size() == 0 && !pend[i] && !busy_v[i]) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) checkOutput("done_timeout", i, 32'd0, 32'd1);
        tick();
    endtask

    task automatic resetPulse(input int i);
        rst_v[i] = 1'b1;
        tick();
        rst_v[i] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            rst_v[i]     = 1'b1;
            valid_v[i]   = 1'b0;
            data_v[i]    = '0;
            bits_left[i] = 0;
            gap_left[i]  = 0;
            coll[i]      = '0;
            pend[i]      = 1'b0;
            pend_cnt[i]  = '0;
        end
        tick();
        tick();
        for (int i = 0; i < 4; i++) rst_v[i] = 1'b0;

        // Reset state.
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checkOutput("rst_frame_o", i, 32'(fo_v[i]), 32'd0);
            checkOutput("rst_cnt", i, 32'(cnt_v[i]), 32'd0);
            checkOutput("rst_ser", i, 32'(ser_v[i]), 32'd0);
        end
        tick();

        // Basic frame, MSB first: 101 -> 11011.
        applyStimulus(0, 3'b101, 5'b11011, 5'b11011, 4'd1);
        waitDone(0);

        // LSB first: 100 -> frame 11001, stream 1,0,0,1,1.
        applyStimulus(1, 3'b100, 5'b10011, 5'b11001, 4'd1);
        waitDone(1);

        // Back-to-back with no gap: 000 then 111, continuous 10 bits.
        resetPulse(0);
        applyStimulus(0, 3'b000, 5'b10001, 5'b10001, 4'd1);
        applyStimulus(0, 3'b111, 5'b11111, 5'b11111, 4'd2);
        waitDone(0);

        // Two-cycle gap between frames.
        applyStimulus(2, 3'b010, 5'b10101, 5'b10101, 4'd1);
        applyStimulus(2, 3'b110, 5'b11101, 5'b11101, 4'd2);
        waitDone(2);

        // Reset in the k=2 cycle abandons the frame.
        data_v[0]  = 3'b011;
        valid_v[0] = 1'b1;
        @(negedge clk);
        checkOutput("ready_before_abort", 0, 32'(rdy_v[0]), 32'd1);
        tick();
        valid_v[0] = 1'b0;
        tick();
        tick();
        rst_v[0] = 1'b1;
        tick();
        rst_v[0] = 1'b0;
        @(negedge clk);
        checkOutput("abort_ser", 0, 32'(ser_v[0]), 32'd0);
        checkOutput("abort_frame_o", 0, 32'(fo_v[0]), 32'd0);
        checkOutput("abort_cnt", 0, 32'(cnt_v[0]), 32'd0);
        checkOutput("abort_ready", 0, 32'(rdy_v[0]), 32'd1);
        tick();

        // Reset wins over an accept on the same edge.
        rst_v[0]   = 1'b1;
        valid_v[0] = 1'b1;
        data_v[0]  = 3'b111;
        tick();
        rst_v[0]   = 1'b0;
        valid_v[0] = 1'b0;
        @(negedge clk);
        checkOutput("rst_accept_busy", 0, 32'(busy_v[0]), 32'd0);
        checkOutput("rst_accept_ready", 0, 32'(rdy_v[0]), 32'd1);
        checkOutput("rst_accept_frame_o", 0, 32'(fo_v[0]), 32'd0);
        tick();
        applyStimulus(0, 3'b001, 5'b10011, 5'b10011, 4'd1);
        waitDone(0);

        // Two-bit counter wrap with GAP=1; valid pulses while busy are ignored.
        applyStimulus(3, 3'b001, 5'b10011, 5'b10011, 4'd1);
        tick();
        data_v[3] = 3'b110; valid_v[3] = 1'b1;
        tick();
        valid_v[3] = 1'b0;
        applyStimulus(3, 3'b010, 5'b10101, 5'b10101, 4'd2);
        tick();
        data_v[3] = 3'b111; valid_v[3] = 1'b1;
        tick();
        valid_v[3] = 1'b0;
        @(negedge clk);
        checkOutput("frame_o_hold", 3, 32'(fo_v[3]), 32'h15);
        tick();
        applyStimulus(3, 3'b011, 5'b10111, 5'b10111, 4'd3);
        applyStimulus(3, 3'b100, 5'b11001, 5'b11001, 4'd0);
        applyStimulus(3, 3'b101, 5'b11011, 5'b11011, 4'd1);
        waitDone(3);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
